// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-0 SPI master moving one DATA_W-bit word per start, paced by a ce half-period tick.
module spi_byte_master #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
  logic [CW-1:0]     cnt_q;
  logic              sclk_q, mosi_q, cs_n_q, done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign busy    = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          tx_q    <= tx_data;
          rx_q    <= '0;
          cnt_q   <= '0;
          cs_n_q  <= 1'b0;
          mosi_q  <= LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
          state_q <= LEAD;
        end
        LEAD: if (ce) state_q <= XFER;
        XFER: if (ce) begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;
            rx_q   <= LSB_FIRST ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
          end else begin
            sclk_q <= 1'b0;
            if (cnt_q == CW'(DATA_W - 1)) begin
              state_q <= TRAIL;
            end else begin
              // mosi only moves on the falling edge, so the slave sees a stable bit while sclk is high
              cnt_q  <= cnt_q + CW'(1);
              tx_q   <= LSB_FIRST ? tx_q >> 1 : tx_q << 1;
              mosi_q <= LSB_FIRST ? tx_q[1] : tx_q[DATA_W-2];
            end
          end
        end
        TRAIL: if (ce) begin
          cs_n_q    <= 1'b1;
          rx_data_q <= rx_q;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 Parameter DATA_W, default 8, shall set the transfer width in bits (legal range 2..16).
REQ-002 Parameter LSB_FIRST, default 0, shall select bit order: 0 = MSB first, 1 = LSB first.
REQ-003 clk  input  1  shall be the single clock; all state shall change on its rising edge.
REQ-004 rst_n  input  1  shall be the reset: asynchronous, active-low.
REQ-005 ce  input  1  shall be the bit-rate enable tick, one clk wide, from the upstream ceo divider; each ce shall advance one SCLK half-period.
REQ-006 start  input  1  shall request a transfer; it is sampled only in IDLE.
REQ-007 tx_data  input  DATA_W  shall be the word to send, latched when start is accepted.
REQ-008 miso  input  1  shall be the serial data from the slave.
REQ-009 sclk  output  1  shall be the SPI clock in mode 0 (CPOL=0, CPHA=0).
REQ-010 mosi  output  1  shall be the serial data to the slave.
REQ-011 cs_n  output  1  shall be the active-low slave select.
REQ-012 rx_data  output  DATA_W  shall be the last completed received word.
REQ-013 busy  output  1  shall be high in every state except IDLE.
REQ-014 done  output  1  shall be a one-clk pulse marking transfer completion.

Function
REQ-015 FSM states shall be IDLE, LEAD, XFER and TRAIL; ce shall be ignored in IDLE.
REQ-016 IDLE with start=1 shall, on that edge and regardless of ce: latch tx_data into the TX shift register, clear the bit counter and RX shift register, drive cs_n=0, drive mosi with the first bit (tx_data[DATA_W-1], or tx_data[0] if LSB_FIRST), and go to LEAD.
REQ-017 LEAD shall wait one ce with sclk=0 (setup half-period), then go to XFER.
REQ-018 XFER, on ce with sclk=0, shall set sclk=1 and shift miso into the RX shift register in the configured bit order.
REQ-019 XFER, on ce with sclk=1, shall set sclk=0; if bit counter = DATA_W-1 it shall go to TRAIL, otherwise it shall increment the counter and drive the next TX bit on mosi.
REQ-020 TRAIL, on ce, shall drive cs_n=1, load rx_data from the RX shift register, assert done for exactly one clk, and return to IDLE.
REQ-021 A transfer shall take exactly 2*DATA_W+2 ce ticks after start acceptance (18 for DATA_W=8); done shall be high in the clk cycle following the final ce edge.
REQ-022 start while busy shall be ignored, with no effect on the transfer in progress.
REQ-023 start in the cycle done is high shall be accepted, since the FSM is already in IDLE; back-to-back transfers shall be legal.
REQ-024 ce held continuously high shall be legal and shall give an SCLK period of 2 clk.
REQ-025 mosi shall change only on a sclk falling edge or on start acceptance, never while sclk=1.
REQ-026 rx_data shall hold its value between transfers and change only in TRAIL.
REQ-027 The bit counter shall be ceil(log2(DATA_W)) bits wide and shall never wrap within a transfer.

Reset
REQ-028 rst_n=0 shall immediately, without waiting for clk, force: state=IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, and clear the shift registers and counter.
REQ-029 Reset asserted mid-transfer shall abort it with no done pulse and rx_data=0; the first start after rst_n deasserts shall begin a clean transfer.

Verification
REQ-030 Loopback (miso=mosi), tx_data=0xA5, ce every 4 clk -> rx_data=0xA5, exactly 8 sclk rising edges, done once, 18 ce ticks after start.
REQ-031 miso tied 1, tx_data=0x00, ce held high -> rx_data=0xFF, sclk period 2 clk, mosi constantly 0, cs_n low for 18 clk.
REQ-032 start pulsed again at bit 3 with tx_data=0x3C while the 0xA5 transfer runs -> it is ignored and the loopback rx_data=0xA5.
REQ-033 rst_n pulsed low at bit 4 -> cs_n=1, sclk=0 and busy=0 asynchronously, no done; the next transfer of 0x5A returns 0x5A.
REQ-034 LSB_FIRST=1, tx_data=0x01 -> first mosi bit 1, remaining 7 bits 0; loopback rx_data=0x01.
REQ-035 start held high through done -> second transfer starts in the done cycle, with cs_n high for at most 1 clk between frames.
